rvseed_sim_monitor: RTL and testbench

//  Synthesizable end-of-test monitor for rvseed. Snoops the register-file write port,

---
 rtl/rvseed_sim_monitor_pkg.sv | 24 ++
 rtl/rvseed_sat_cnt.sv | 28 ++
 rtl/rvseed_sim_monitor.sv | 131 +++++++++++++
 tb/tb_rvseed_sim_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rvseed_sim_monitor_pkg.sv
// rvseed_sim_monitor_pkg: shared state codes and register-index defaults for the end-of-test monitor
//   No ports. Provides the FSM state type and codes, the default done/pass/testnum
//   register indices and data width, and a terminal-state helper.
package rvseed_sim_monitor_pkg;

   typedef logic [2:0] sim_state_t;

   localparam sim_state_t SIM_ST_RUN     = 3'd0;
   localparam sim_state_t SIM_ST_SETTLE  = 3'd1;
   localparam sim_state_t SIM_ST_PASS    = 3'd2;
   localparam sim_state_t SIM_ST_FAIL    = 3'd3;
   localparam sim_state_t SIM_ST_TIMEOUT = 3'd4;

   localparam int SIM_CPU_WIDTH = 32;
   localparam int SIM_DONE_REG  = 26;
   localparam int SIM_PASS_REG  = 27;
   localparam int SIM_TNUM_REG  = 3;

   // Verdict states are coded above SETTLE so one compare identifies them.
   function automatic logic sim_is_terminal(input sim_state_t st);
      return st >= SIM_ST_PASS;
   endfunction

endpackage

// File: rtl/rvseed_sat_cnt.sv
// rvseed_sat_cnt: CNT_WIDTH-bit up-counter that sticks at all-ones
//   clk    in   core clock
//   rst    in   synchronous reset, active-high, clears the count
//   clr_i  in   synchronous clear (lower priority than rst, higher than en_i)
//   en_i   in   count enable
//   cnt_o  out  current count
module rvseed_sat_cnt #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 en_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr_i ? '0 : (en_i && ~&cnt_q) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rvseed_sim_monitor.sv
// rvseed_sim_monitor: snoops register-file writes and issues a sticky PASS/FAIL/TIMEOUT verdict
//   clk, rst            core clock, synchronous active-high reset
//   rf_we/waddr/wdata   register-file write port being snooped
//   retire              one pulse per retired instruction
//   sim_done            verdict reached (sticky)
//   sim_pass/fail/timeout  exactly one set alongside sim_done
//   fail_testnum        testnum shadow on FAIL/TIMEOUT, 0 on PASS
//   cycle_cnt           cycles spent in RUN and SETTLE
//   retire_cnt          retire pulses seen in RUN and SETTLE
module rvseed_sim_monitor
   import rvseed_sim_monitor_pkg::*;
#(
   parameter int CPU_WIDTH   = SIM_CPU_WIDTH,
   parameter int DONE_REG    = SIM_DONE_REG,
   parameter int PASS_REG    = SIM_PASS_REG,
   parameter int TNUM_REG    = SIM_TNUM_REG,
   parameter int DONE_VAL    = 1,
   parameter int PASS_VAL    = 1,
   parameter int SETTLE_CYC  = 1,
   parameter int TIMEOUT_CYC = 50000,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rf_we,
   input  logic [4:0]           rf_waddr,
   input  logic [CPU_WIDTH-1:0] rf_wdata,
   input  logic                 retire,
   output logic                 sim_done,
   output logic                 sim_pass,
   output logic                 sim_fail,
   output logic                 sim_timeout,
   output logic [CPU_WIDTH-1:0] fail_testnum,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] retire_cnt
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   sim_state_t           state_q, state_d;
   logic [SW-1:0]        settle_q, settle_d;
   logic [CPU_WIDTH-1:0] pass_sh_q, pass_sh_d;
   logic [CPU_WIDTH-1:0] tnum_sh_q, tnum_sh_d;
   logic                 done_q, pass_q, fail_q, timeout_q;
   logic [CPU_WIDTH-1:0] testnum_q;
   logic                 active, wr, done_trig, at_timeout;

   // The done register acts on the write itself, so it needs no shadow copy.
   assign active     = (state_q == SIM_ST_RUN) || (state_q == SIM_ST_SETTLE);
   assign wr         = rf_we && (rf_waddr != 5'd0) && active;
   assign done_trig  = (state_q == SIM_ST_RUN) && wr && (rf_waddr == 5'(DONE_REG))
                       && (rf_wdata == CPU_WIDTH'(DONE_VAL));
   // Widened compare so a narrow counter can never alias onto the timeout value.
   assign at_timeout = 64'(cycle_cnt) == 64'(TIMEOUT_CYC - 1);

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      if (state_q == SIM_ST_RUN) begin
         if (done_trig) begin
            state_d  = SIM_ST_SETTLE;
            settle_d = SW'(SETTLE_CYC - 1);
         end else if (at_timeout) begin
            state_d  = SIM_ST_TIMEOUT;
         end
      end else if (state_q == SIM_ST_SETTLE) begin
         // Verdict uses the registered shadow; a PASS write in this cycle is too late.
         if (settle_q == '0) state_d = (pass_sh_q == CPU_WIDTH'(PASS_VAL)) ? SIM_ST_PASS : SIM_ST_FAIL;
         else                settle_d = settle_q - SW'(1);
      end
   end

   always_comb begin
      pass_sh_d = (wr && rf_waddr == 5'(PASS_REG)) ? rf_wdata : pass_sh_q;
      tnum_sh_d = (wr && rf_waddr == 5'(TNUM_REG)) ? rf_wdata : tnum_sh_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SIM_ST_RUN;
         settle_q  <= '0;
         pass_sh_q <= '0;
         tnum_sh_q <= '0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         pass_sh_q <= pass_sh_d;
         tnum_sh_q <= tnum_sh_d;
      end
   end

   // Verdict outputs are registered from the state, landing one cycle after the transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         testnum_q <= '0;
      end else begin
         done_q    <= sim_is_terminal(state_q);
         pass_q    <= state_q == SIM_ST_PASS;
         fail_q    <= state_q == SIM_ST_FAIL;
         timeout_q <= state_q == SIM_ST_TIMEOUT;
         testnum_q <= (state_q == SIM_ST_FAIL || state_q == SIM_ST_TIMEOUT) ? tnum_sh_q : '0;
      end
   end

   rvseed_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .en_i  (active),
      .cnt_o (cycle_cnt)
   );

   rvseed_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_retire_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .en_i  (active && retire),
      .cnt_o (retire_cnt)
   );

   assign sim_done     = done_q;
   assign sim_pass     = pass_q;
   assign sim_fail     = fail_q;
   assign sim_timeout  = timeout_q;
   assign fail_testnum = testnum_q;

endmodule

// File: tb/tb_rvseed_sim_monitor.sv
// tb_rvseed_sim_monitor: directed vectors and a reference model for the end-of-test monitor
module tb_rvseed_sim_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rf_we = 1'b0;
   logic [4:0]  rf_waddr = 5'd0;
   logic [31:0] rf_wdata = 32'd0;
   logic        retire = 1'b0;

   logic [3:0]  a_fl, b_fl, c_fl;
   logic [31:0] a_tn, b_tn, a_cyc, a_ret, b_cyc, b_ret;
   logic [31:0] c_tn;
   logic [3:0]  c_cyc, c_ret;

   int errors = 0;
   int checks = 0;

   localparam logic [3:0] PASS = 4'b1100;
   localparam logic [3:0] FAIL_V = 4'b1010;
   localparam logic [3:0] TMO = 4'b1001;

   always #5 clk = ~clk;

   rvseed_sim_monitor #(.SETTLE_CYC(1), .TIMEOUT_CYC(20), .CNT_WIDTH(32)) u_a (
      .clk(clk), .rst(rst), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire),
      .sim_done(a_fl[3]), .sim_pass(a_fl[2]), .sim_fail(a_fl[1]), .sim_timeout(a_fl[0]),
      .fail_testnum(a_tn), .cycle_cnt(a_cyc), .retire_cnt(a_ret)
   );

   rvseed_sim_monitor #(.SETTLE_CYC(2), .TIMEOUT_CYC(20), .CNT_WIDTH(32)) u_b (
      .clk(clk), .rst(rst), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire),
      .sim_done(b_fl[3]), .sim_pass(b_fl[2]), .sim_fail(b_fl[1]), .sim_timeout(b_fl[0]),
      .fail_testnum(b_tn), .cycle_cnt(b_cyc), .retire_cnt(b_ret)
   );

   rvseed_sim_monitor #(.SETTLE_CYC(1), .CNT_WIDTH(4)) u_c (
      .clk(clk), .rst(rst), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire),
      .sim_done(c_fl[3]), .sim_pass(c_fl[2]), .sim_fail(c_fl[1]), .sim_timeout(c_fl[0]),
      .fail_testnum(c_tn), .cycle_cnt(c_cyc), .retire_cnt(c_ret)
   );

   typedef struct {
      logic        r;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        ret;
      logic [3:0]  fa;
      logic [31:0] tn;
      logic [31:0] cyc;
      logic [31:0] rc;
      logic [3:0]  fb;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic we, input logic [4:0] a, input logic [31:0] d, input logic ret);
      @(negedge clk);
      rst = r; rf_we = we; rf_waddr = a; rf_wdata = d; retire = ret;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ret);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, ret);
   endtask

   int          m_st;
   logic [31:0] m_psh, m_tsh, m_tn;
   logic [3:0]  m_cyc, m_ret, m_fl;
   logic        r_r, r_we, r_ret, m_act, m_wr;
   logic [4:0]  r_a;
   logic [31:0] r_d;

   initial begin
      //          r  we addr data ret  fa      tn  cyc rc  fb
      tbl[0]  = '{1, 0, 0,  0,   0,   4'b0,   0,  0,  0,  4'b0};
      tbl[1]  = '{0, 1, 3,  5,   1,   4'b0,   0,  1,  1,  4'b0};
      tbl[2]  = '{0, 1, 27, 1,   1,   4'b0,   0,  2,  2,  4'b0};
      tbl[3]  = '{0, 1, 26, 1,   0,   4'b0,   0,  3,  2,  4'b0};
      tbl[4]  = '{0, 0, 0,  0,   1,   4'b0,   0,  4,  3,  4'b0};
      tbl[5]  = '{0, 0, 0,  0,   1,   PASS,   0,  4,  3,  4'b0};
      tbl[6]  = '{0, 0, 0,  0,   0,   PASS,   0,  4,  3,  PASS};
      tbl[7]  = '{1, 0, 0,  0,   0,   4'b0,   0,  0,  0,  4'b0};
      tbl[8]  = '{0, 1, 3,  7,   0,   4'b0,   0,  1,  0,  4'b0};
      tbl[9]  = '{0, 1, 27, 0,   0,   4'b0,   0,  2,  0,  4'b0};
      tbl[10] = '{0, 1, 26, 1,   0,   4'b0,   0,  3,  0,  4'b0};
      tbl[11] = '{0, 0, 0,  0,   0,   4'b0,   0,  4,  0,  4'b0};
      tbl[12] = '{0, 0, 0,  0,   0,   FAIL_V, 7,  4,  0,  4'b0};
      tbl[13] = '{0, 0, 0,  0,   0,   FAIL_V, 7,  4,  0,  FAIL_V};
      tbl[14] = '{1, 0, 0,  0,   0,   4'b0,   0,  0,  0,  4'b0};
      tbl[15] = '{0, 1, 26, 1,   0,   4'b0,   0,  1,  0,  4'b0};
      tbl[16] = '{0, 1, 27, 1,   0,   4'b0,   0,  2,  0,  4'b0};
      tbl[17] = '{0, 0, 0,  0,   0,   FAIL_V, 0,  2,  0,  4'b0};
      tbl[18] = '{0, 0, 0,  0,   0,   FAIL_V, 0,  2,  0,  PASS};

      for (int i = 0; i < 19; i++) begin
         step(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].ret);
         chk($sformatf("vec%0d a_flags", i), 64'(a_fl), 64'(tbl[i].fa));
         chk($sformatf("vec%0d a_testnum", i), 64'(a_tn), 64'(tbl[i].tn));
         chk($sformatf("vec%0d a_cycle_cnt", i), 64'(a_cyc), 64'(tbl[i].cyc));
         chk($sformatf("vec%0d a_retire_cnt", i), 64'(a_ret), 64'(tbl[i].rc));
         chk($sformatf("vec%0d b_flags", i), 64'(b_fl), 64'(tbl[i].fb));
         if (i == 13)
            for (int k = 0; k < 100; k++) begin
               step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
               chk("fail_hold", {28'd0, a_fl, a_tn}, {28'd0, FAIL_V, 32'd7});
            end
      end

      // Timeout with no done write; narrow counters saturate along the way.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 5'd3, 32'd9, 1'b1);
      idle(19, 1'b1);
      chk("tmo_pre_flags", 64'(a_fl), 64'(0));
      chk("tmo_cycle_cnt", 64'(a_cyc), 64'(20));
      chk("tmo_retire_cnt", 64'(a_ret), 64'(20));
      chk("sat_cycle_cnt", 64'(c_cyc), 64'(15));
      chk("sat_retire_cnt", 64'(c_ret), 64'(15));
      idle(1, 1'b1);
      chk("tmo_a_flags", 64'(a_fl), 64'(TMO));
      chk("tmo_a_testnum", 64'(a_tn), 64'(9));
      chk("tmo_a_cycle_hold", 64'(a_cyc), 64'(20));
      chk("tmo_a_retire_hold", 64'(a_ret), 64'(20));
      chk("tmo_b_flags", 64'(b_fl), 64'(TMO));
      chk("tmo_c_flags", 64'(c_fl), 64'(0));
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("rst_flags", {a_fl, a_tn, a_cyc, a_ret}, 100'd0);
      idle(1, 1'b0);
      chk("rst_run_cycle", 64'(a_cyc), 64'(1));

      // Done write coinciding with the last pre-timeout cycle; x26=2 and x0 writes are inert.
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      idle(4, 1'b0);
      step(1'b0, 1'b1, 5'd26, 32'd2, 1'b0);
      step(1'b0, 1'b1, 5'd0, 32'd1, 1'b0);
      idle(13, 1'b0);
      chk("race_pre_flags", 64'(a_fl), 64'(0));
      chk("race_pre_cycle", 64'(a_cyc), 64'(19));
      step(1'b0, 1'b1, 5'd26, 32'd1, 1'b0);
      chk("race_e20_cycle", 64'(a_cyc), 64'(20));
      idle(1, 1'b0);
      chk("race_e21_flags", 64'(a_fl), 64'(0));
      idle(1, 1'b0);
      chk("race_a_flags", 64'(a_fl), 64'(FAIL_V));
      chk("race_a_cycle", 64'(a_cyc), 64'(21));
      idle(1, 1'b0);
      chk("race_b_flags", 64'(b_fl), 64'(FAIL_V));

      // Random writes and retires against a reference model of the 4-bit-counter instance.
      m_st = 0; m_psh = 0; m_tsh = 0; m_tn = 0; m_cyc = 0; m_ret = 0; m_fl = 0;
      for (int i = 0; i < 300; i++) begin
         r_r = (i % 37) == 0;
         r_we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: r_a = 5'd0;
            1: r_a = 5'd3;
            2: r_a = 5'd26;
            3: r_a = 5'd27;
            default: r_a = 5'($urandom_range(0, 31));
         endcase
         case ($urandom_range(0, 3))
            0: r_d = 32'd0;
            1: r_d = 32'd1;
            2: r_d = 32'd2;
            default: r_d = $urandom;
         endcase
         r_ret = 1'($urandom_range(0, 1));
         step(r_r, r_we, r_a, r_d, r_ret);
         if (r_r) begin
            m_st = 0; m_psh = 0; m_tsh = 0; m_tn = 0; m_cyc = 0; m_ret = 0; m_fl = 0;
         end else begin
            m_act = m_st < 2;
            m_wr = r_we && r_a != 0 && m_act;
            m_fl = {m_st >= 2, m_st == 2, m_st == 3, m_st == 4};
            m_tn = (m_st == 3 || m_st == 4) ? m_tsh : 32'd0;
            if (m_act && m_cyc != 4'hf) m_cyc = m_cyc + 4'd1;
            if (m_act && r_ret && m_ret != 4'hf) m_ret = m_ret + 4'd1;
            if (m_st == 0 && m_wr && r_a == 26 && r_d == 1) m_st = 1;
            else if (m_st == 1) m_st = (m_psh == 1) ? 2 : 3;
            if (m_wr && r_a == 27) m_psh = r_d;
            if (m_wr && r_a == 3) m_tsh = r_d;
         end
         chk($sformatf("rand%0d", i), {20'd0, c_fl, c_tn, c_cyc, c_ret}, {20'd0, m_fl, m_tn, m_cyc, m_ret});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
